uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Serial UART receiver; consumes the tx_out line of the UART transmitter and
//  rebuilds its parallel byte. Frame: start(0), DATA_WIDTH bits LSB first,
//  optional parity, stop(1). Uses per-bit oversampling with 3-sample majority
//  vote. Reports parity and stop (framing) errors.
// PARAMETERS
//  DATA_WIDTH      8   payload bits per frame
//  PRESCALE_WIDTH  6   width of prescale input (max oversampling 2^W-1)
// PORTS
//  clk        in   1               single clock; all logic on rising edge
//  rst        in   1               synchronous, active-high reset
//  rx_in      in   1               serial line; idle high; asynchronous to clk
//  prescale   in   PRESCALE_WIDTH  clk cycles per bit; even, >=4
//  par_en     in   1               1: parity bit present after data
//  par_type   in   1               0: even parity, 1: odd parity
//  p_data     out  DATA_WIDTH      last good received word
//  data_valid out  1               1-cycle pulse: p_data updated
//  par_err    out  1               1-cycle pulse: parity mismatch
//  stp_err    out  1               1-cycle pulse: stop bit sampled 0
//  busy       out  1               high while a frame is being received
// BEHAVIOUR
//  - Reset: state IDLE, p_data=0, data_valid=0, par_err=0, stp_err=0, busy=0.
//    Reset mid-frame aborts the frame; no output pulses are generated.
//  - rx_in passes through a 2-flop synchronizer (rx_s); all timing refers to rx_s.
//  - The frame latches prescale, par_en and par_type on start detect.
//    Input changes during the frame are ignored.
//  - edge_cnt counts 0..P-1 per bit (P = latched prescale). bit_cnt indexes data bits.
//  - Sample = majority of rx_s at edge_cnt = P/2-1, P/2, P/2+1.
//    The bit value is decided at edge_cnt = P/2+1.
//  - FSM:
//    IDLE: busy=0; rx_s==0 -> START, edge_cnt=0, busy=1.
//    START: sampled 0 -> continues to edge_cnt=P-1, then DATA.
//      sampled 1 (glitch) -> IDLE immediately, busy=0, no pulses.
//    DATA: shift samples in LSB first.
//      After bit DATA_WIDTH-1 ends -> PARITY if par_en, else STOP.
//    PARITY: computed parity is ^data (even) or ~^data (odd).
//      A mismatch is recorded and reported at the STOP decision.
//    STOP: at the sample decision (edge_cnt=P/2+1), exactly one of these occurs
//      on the next cycle:
//      no error -> data_valid=1, p_data=received word;
//      otherwise par_err and/or stp_err=1, p_data unchanged, data_valid=0.
//      The state returns to IDLE at that same decision point, so a new start
//      edge in the second half of the stop bit is accepted (back-to-back frames).
//  - Pulses last exactly 1 clk. p_data holds until the next good frame.
//  - Latency: rx_in mid-stop to data_valid = 2 (sync) + 1 clk.
//  - Line held low through the stop sample -> stp_err. After that the FSM
//    immediately sees rx_s==0 and starts a new frame (by design; no break detection).
//  - Counter width: edge_cnt is PRESCALE_WIDTH bits. bit_cnt is
//    $clog2(DATA_WIDTH)+1 bits. There is no wrap within a bit.
// TESTING
//  1 prescale=8, par_en=1, par_type=0, send 0xA5 (parity 0)
//    -> one data_valid pulse, p_data=0xA5, no errors, busy low after.
//  2 same config, send 0x3C with parity bit forced 1
//    -> par_err pulse, data_valid=0, p_data keeps previous 0xA5.
//  3 par_en=0, send 0x81 with stop bit 0
//    -> stp_err pulse only; then line high -> FSM IDLE, busy=0.
//  4 3-clk low glitch on idle line (prescale=16)
//    -> START aborts, busy returns 0, no pulses.
//  5 ten frames back-to-back, no idle gap (prescale=8, even parity)
//    -> ten data_valid pulses in order, matching bytes.
//  6 assert rst mid-DATA of frame 0x55, then send 0x0F cleanly
//    -> no pulse for 0x55; 0x0F received with data_valid.

Source files
------------

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//   Serial UART receiver. Rebuilds the parallel word from a frame of
//   start(0), DATA_WIDTH data bits LSB first, optional parity and stop(1).
//   Each bit is oversampled `prescale` times and decided by a 3-sample
//   majority vote around the middle of the bit.
//
// Ports
//   clk        : single clock, all logic on the rising edge
//   rst        : synchronous, active-high reset
//   rx_in      : serial line, idle high, asynchronous to clk
//   prescale   : clk cycles per bit (even, >= 4), latched at start detect
//   par_en     : 1 = a parity bit follows the data bits
//   par_type   : 0 = even parity, 1 = odd parity
//   p_data     : last correctly received word (held until next good frame)
//   data_valid : 1-cycle pulse, p_data has just been updated
//   par_err    : 1-cycle pulse, parity mismatch in the finished frame
//   stp_err    : 1-cycle pulse, stop bit sampled as 0
//   busy       : high while a frame is being received
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx_in,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      par_en,
  input  logic                      par_type,
  output logic [DATA_WIDTH-1:0]     p_data,
  output logic                      data_valid,
  output logic                      par_err,
  output logic                      stp_err,
  output logic                      busy
);

  localparam int BIT_CNT_WIDTH = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Expected parity bit for a data word: even parity makes the total number
  // of ones even, odd parity makes it odd.
  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] data,
                                      input logic                  odd);
    parity_bit = odd ? ~^data : ^data;
  endfunction

  state_t                    state_r;
  logic                      rx_meta_r;
  logic                      rx_sync_r;
  logic [PRESCALE_WIDTH-1:0] prescale_r;
  logic                      par_en_r;
  logic                      par_type_r;
  logic [PRESCALE_WIDTH-1:0] edge_cnt_r;
  logic [BIT_CNT_WIDTH-1:0]  bit_cnt_r;
  logic [DATA_WIDTH-1:0]     shift_r;
  logic                      sample1_r;
  logic                      sample2_r;
  logic                      par_bad_r;

  logic [PRESCALE_WIDTH-1:0] half_s;
  logic [PRESCALE_WIDTH-1:0] mid_lo_s;
  logic [PRESCALE_WIDTH-1:0] mid_hi_s;
  logic [PRESCALE_WIDTH-1:0] last_s;
  logic                      at_sample1_s;
  logic                      at_sample2_s;
  logic                      at_decide_s;
  logic                      at_end_s;
  logic                      vote_s;
  logic                      last_bit_s;

  // Two-flop synchronizer for the asynchronous serial line (resets to idle).
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx_in;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Sample-point decode and majority vote; the third sample is the live rx_s
  // at the decision point, so the vote is available in the deciding cycle.
  always_comb begin
    half_s       = {1'b0, prescale_r[PRESCALE_WIDTH-1:1]};
    mid_lo_s     = half_s - PRESCALE_WIDTH'(1);
    mid_hi_s     = half_s + PRESCALE_WIDTH'(1);
    last_s       = prescale_r - PRESCALE_WIDTH'(1);
    at_sample1_s = (edge_cnt_r == mid_lo_s);
    at_sample2_s = (edge_cnt_r == half_s);
    at_decide_s  = (edge_cnt_r == mid_hi_s);
    at_end_s     = (edge_cnt_r == last_s);
    vote_s       = (sample1_r & sample2_r) | (sample1_r & rx_sync_r) |
                   (sample2_r & rx_sync_r);
    last_bit_s   = (bit_cnt_r == BIT_CNT_WIDTH'(DATA_WIDTH - 1));
  end

  // Receive FSM with counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      prescale_r <= {PRESCALE_WIDTH{1'b0}};
      par_en_r   <= 1'b0;
      par_type_r <= 1'b0;
      edge_cnt_r <= {PRESCALE_WIDTH{1'b0}};
      bit_cnt_r  <= {BIT_CNT_WIDTH{1'b0}};
      shift_r    <= {DATA_WIDTH{1'b0}};
      sample1_r  <= 1'b0;
      sample2_r  <= 1'b0;
      par_bad_r  <= 1'b0;
      p_data     <= {DATA_WIDTH{1'b0}};
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;

      if (state_r != IDLE && at_sample1_s) begin
        sample1_r <= rx_sync_r;
      end
      if (state_r != IDLE && at_sample2_s) begin
        sample2_r <= rx_sync_r;
      end

      case (state_r)
        IDLE: begin
          edge_cnt_r <= {PRESCALE_WIDTH{1'b0}};
          bit_cnt_r  <= {BIT_CNT_WIDTH{1'b0}};
          par_bad_r  <= 1'b0;
          if (!rx_sync_r) begin
            // Frame configuration is frozen for the whole frame here.
            state_r    <= START;
            busy       <= 1'b1;
            prescale_r <= prescale;
            par_en_r   <= par_en;
            par_type_r <= par_type;
          end else begin
            busy <= 1'b0;
          end
        end

        START: begin
          if (at_decide_s && vote_s) begin
            // Start bit did not hold: treat as a glitch, no pulses.
            state_r    <= IDLE;
            busy       <= 1'b0;
            edge_cnt_r <= {PRESCALE_WIDTH{1'b0}};
          end else if (at_end_s) begin
            state_r    <= DATA;
            edge_cnt_r <= {PRESCALE_WIDTH{1'b0}};
          end else begin
            edge_cnt_r <= edge_cnt_r + PRESCALE_WIDTH'(1);
          end
        end

        DATA: begin
          if (at_decide_s) begin
            // LSB arrives first, so shift in from the top.
            shift_r <= {vote_s, shift_r[DATA_WIDTH-1:1]};
          end
          if (at_end_s) begin
            edge_cnt_r <= {PRESCALE_WIDTH{1'b0}};
            if (last_bit_s) begin
              bit_cnt_r <= {BIT_CNT_WIDTH{1'b0}};
              state_r   <= par_en_r ? PARITY : STOP;
            end else begin
              bit_cnt_r <= bit_cnt_r + BIT_CNT_WIDTH'(1);
            end
          end else begin
            edge_cnt_r <= edge_cnt_r + PRESCALE_WIDTH'(1);
          end
        end

        PARITY: begin
          if (at_decide_s) begin
            par_bad_r <= (vote_s != parity_bit(shift_r, par_type_r));
          end
          if (at_end_s) begin
            edge_cnt_r <= {PRESCALE_WIDTH{1'b0}};
            state_r    <= STOP;
          end else begin
            edge_cnt_r <= edge_cnt_r + PRESCALE_WIDTH'(1);
          end
        end

        STOP: begin
          if (at_decide_s) begin
            // Leave mid-stop so a start edge right after this bit is caught.
            state_r    <= IDLE;
            busy       <= 1'b0;
            edge_cnt_r <= {PRESCALE_WIDTH{1'b0}};
            if (!vote_s || par_bad_r) begin
              par_err <= par_bad_r;
              stp_err <= ~vote_s;
            end else begin
              data_valid <= 1'b1;
              p_data     <= shift_r;
            end
          end else begin
            edge_cnt_r <= edge_cnt_r + PRESCALE_WIDTH'(1);
          end
        end

        default: begin
          state_r    <= IDLE;
          busy       <= 1'b0;
          edge_cnt_r <= {PRESCALE_WIDTH{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;

  logic       clk;
  logic       rst;
  logic       rx_in;
  logic [5:0] prescale;
  logic       par_en;
  logic       par_type;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;
  logic       busy;

  typedef struct packed {
    logic       dv;
    logic       pe;
    logic       se;
    logic [7:0] d;
  } ev_t;

  ev_t        got_q[$];
  ev_t        exp_q[$];
  logic [7:0] last_good;
  int         errors;
  int         checks;

  uart_rx #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .prescale   (prescale),
    .par_en     (par_en),
    .par_type   (par_type),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every output pulse, one entry per cycle in which any pulse is high.
  always @(negedge clk) begin
    if (!rst && (data_valid || par_err || stp_err)) begin
      ev_t e;
      e.dv = data_valid;
      e.pe = par_err;
      e.se = stp_err;
      e.d  = p_data;
      got_q.push_back(e);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  // Drive one frame and append the expected outcome to the reference queue.
  task automatic send_frame(input logic [7:0] data, input int p, input bit pen,
                            input bit ptype, input bit flip_par, input bit stop_val,
                            input bit scramble);
    int  ones;
    bit  pbit;
    bit  exp_pe;
    bit  exp_se;
    ev_t e;
    ones = $countones(data);
    // Parity bit that makes the total count of ones even (or odd).
    pbit = ptype ? ((ones % 2) == 0) : ((ones % 2) == 1);
    if (flip_par) pbit = !pbit;
    prescale = 6'(p);
    par_en   = pen;
    par_type = ptype;
    rx_in    = 1'b0;
    repeat (p) @(negedge clk);
    if (scramble) begin
      prescale = 6'($urandom_range(2, 31) * 2);
      par_en   = 1'($urandom);
      par_type = 1'($urandom);
    end
    for (int i = 0; i < 8; i++) begin
      rx_in = data[i];
      repeat (p) @(negedge clk);
    end
    if (pen) begin
      rx_in = pbit;
      repeat (p) @(negedge clk);
    end
    rx_in = stop_val;
    repeat (p) @(negedge clk);
    rx_in = 1'b1;
    exp_pe = pen && flip_par;
    exp_se = !stop_val;
    if (exp_pe || exp_se) begin
      e.dv = 1'b0; e.pe = exp_pe; e.se = exp_se; e.d = last_good;
    end else begin
      e.dv = 1'b1; e.pe = 1'b0; e.se = 1'b0; e.d = data;
      last_good = data;
    end
    exp_q.push_back(e);
  endtask

  task automatic settle(input int p);
    rx_in = 1'b1;
    repeat (8 * p) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (p_data !== 8'h00) begin errors++; $display("FAIL reset_p_data: got %h, required 00", p_data); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid: got %b, required 0", data_valid); end
    checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL reset_par_err: got %b, required 0", par_err); end
    checks++; if (stp_err !== 1'b0) begin errors++; $display("FAIL reset_stp_err: got %b, required 0", stp_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    rst = 1'b0;
    last_good = 8'h00;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_good_frame();
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    settle(8);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL good_busy: got %b, required 0", busy); end
    checks++; if (p_data !== 8'hA5) begin errors++; $display("FAIL good_p_data: got %h, required a5", p_data); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL good_count: got %0d pulses, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL good_event[%0d]: got dv/pe/se/d=%b%b%b/%h, required %b%b%b/%h", i, got_q[i].dv, got_q[i].pe, got_q[i].se, got_q[i].d, exp_q[i].dv, exp_q[i].pe, exp_q[i].se, exp_q[i].d); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_parity_error();
    send_frame(8'h3C, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    settle(8);
    checks++; if (p_data !== 8'hA5) begin errors++; $display("FAIL parity_p_data_hold: got %h, required a5", p_data); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL parity_count: got %0d pulses, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL parity_event[%0d]: got dv/pe/se/d=%b%b%b/%h, required %b%b%b/%h", i, got_q[i].dv, got_q[i].pe, got_q[i].se, got_q[i].d, exp_q[i].dv, exp_q[i].pe, exp_q[i].se, exp_q[i].d); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_stop_error();
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    settle(8);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy: got %b, required 0", busy); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL stop_count: got %0d pulses, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stop_event[%0d]: got dv/pe/se/d=%b%b%b/%h, required %b%b%b/%h", i, got_q[i].dv, got_q[i].pe, got_q[i].se, got_q[i].d, exp_q[i].dv, exp_q[i].pe, exp_q[i].se, exp_q[i].d); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random_frames();
    for (int n = 0; n < 16; n++) begin
      int         p;
      logic [7:0] d;
      p = $urandom_range(2, 10) * 2;
      d = 8'($urandom);
      send_frame(d, p, 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) != 0), 1'b1);
      settle(p);
    end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL random_count: got %0d pulses, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_event[%0d]: got dv/pe/se/d=%b%b%b/%h, required %b%b%b/%h", i, got_q[i].dv, got_q[i].pe, got_q[i].se, got_q[i].d, exp_q[i].dv, exp_q[i].pe, exp_q[i].se, exp_q[i].d); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_glitch();
    bit saw_busy;
    saw_busy = 1'b0;
    prescale = 6'd16;
    rx_in = 1'b0;
    repeat (3) @(negedge clk);
    rx_in = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy === 1'b1) saw_busy = 1'b1;
    end
    checks++; if (saw_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_seen: got %b, required 1", saw_busy); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got %b, required 0", busy); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL glitch_pulses: got %0d pulses, required 0", got_q.size()); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 10; n++) begin
      send_frame(8'($urandom), 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    settle(8);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d pulses, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_event[%0d]: got dv/pe/se/d=%b%b%b/%h, required %b%b%b/%h", i, got_q[i].dv, got_q[i].pe, got_q[i].se, got_q[i].d, exp_q[i].dv, exp_q[i].pe, exp_q[i].se, exp_q[i].d); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] partial;
    partial = 8'h55;
    prescale = 6'd8; par_en = 1'b1; par_type = 1'b0;
    rx_in = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_in = partial[i];
      repeat (8) @(negedge clk);
    end
    rst = 1'b1;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (p_data !== 8'h00) begin errors++; $display("FAIL midrst_p_data: got %h, required 00", p_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b, required 0", busy); end
    rst = 1'b0;
    last_good = 8'h00;
    repeat (20) @(negedge clk);
    send_frame(8'h0F, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    settle(8);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL midrst_count: got %0d pulses, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL midrst_event[%0d]: got dv/pe/se/d=%b%b%b/%h, required %b%b%b/%h", i, got_q[i].dv, got_q[i].pe, got_q[i].se, got_q[i].d, exp_q[i].dv, exp_q[i].pe, exp_q[i].se, exp_q[i].d); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    last_good = 8'h00;
    rst       = 1'b1;
    rx_in     = 1'b1;
    prescale  = 6'd8;
    par_en    = 1'b0;
    par_type  = 1'b0;
    test_reset();
    test_good_frame();
    test_parity_error();
    test_stop_error();
    test_random_frames();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
